// File: rtl/branch_predict_unit_206.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_206
//
// Branch control unit that sits between IF and EX. It has three jobs:
//   * It resolves MIPS conditional branches (beq, bne, bgez, bltz, bgezal,
//     bltzal, bgtz, blez) from the ALU flags.
//   * It owns a branch history table (BHT) of 2-bit saturating counters.
//     The table is read at fetch and trained when a branch resolves.
//   * It flags mispredictions and keeps saturating statistics counters.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   FetchPC         : PC of the instruction in IF
//   PredictTaken    : combinational prediction for FetchPC
//   Branch, OP,
//   BranchFlag      : EX instruction is a branch, plus its OP and rt fields
//   Zero, Sign,
//   OverFlow        : ALU flags for the EX branch
//   ResolvePC       : PC of the EX branch
//   PredTaken       : prediction that travelled down the pipe with the branch
//   ClearStats      : synchronous clear of the statistics counters
//   BranchCtr       : actual branch outcome (combinational)
//   Link            : branch writes $31 (bgezal/bltzal)
//   Mispredict      : outcome differs from the carried prediction
//   BranchCount     : resolved legal branches (registered, saturating)
//   MispredCount    : mispredicted legal branches (registered, saturating)
// ---------------------------------------------------------------------------
module branch_predict_unit_206 #(
  parameter int          PC_W       = 32,
  parameter int          INDEX_W    = 6,
  parameter int          CNT_W      = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    FetchPC,
  output logic               PredictTaken,
  input  logic               Branch,
  input  logic [5:0]         OP,
  input  logic [4:0]         BranchFlag,
  input  logic               Zero,
  input  logic               Sign,
  input  logic               OverFlow,
  input  logic [PC_W-1:0]    ResolvePC,
  input  logic               PredTaken,
  input  logic               ClearStats,
  output logic               BranchCtr,
  output logic               Link,
  output logic               Mispredict,
  output logic [CNT_W-1:0]   BranchCount,
  output logic [CNT_W-1:0]   MispredCount
);

  localparam int DEPTH = 1 << INDEX_W;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // Next value of a 2-bit saturating predictor counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cur == 2'b11) ? cur : cur + 2'b01;
    end else begin
      nxt = (cur == 2'b00) ? cur : cur - 2'b01;
    end
    return nxt;
  endfunction

  // Statistics increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
    logic [CNT_W-1:0] nxt;
    if (&cur) begin
      nxt = cur;
    end else begin
      nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  logic [1:0]         bht_r [DEPTH];
  logic [CNT_W-1:0]   branch_count_r;
  logic [CNT_W-1:0]   mispred_count_r;

  logic [INDEX_W-1:0] fetch_idx_s;
  logic [INDEX_W-1:0] resolve_idx_s;
  logic               legal_s;
  logic               taken_s;
  logic               link_s;
  logic               mispredict_s;
  logic               unused_pc_bits_s;

  // The index is word-aligned. The byte offset and the bits above the index
  // are dropped on purpose, so two PCs may share an entry (aliasing).
  assign fetch_idx_s   = FetchPC[INDEX_W+1:2];
  assign resolve_idx_s = ResolvePC[INDEX_W+1:2];
  assign unused_pc_bits_s = ^{FetchPC[PC_W-1:INDEX_W+2], FetchPC[1:0],
                              ResolvePC[PC_W-1:INDEX_W+2], ResolvePC[1:0]};

  // The prediction is a direct read of the table with no write bypass. A
  // branch that trains the same entry this cycle shows up on the next cycle.
  assign PredictTaken = bht_r[fetch_idx_s][1];

  // Decode the branch encoding and evaluate its condition from the ALU flags.
  always_comb begin
    legal_s = 1'b0;
    taken_s = 1'b0;
    link_s  = 1'b0;
    if (Branch) begin
      case (OP)
        OP_BEQ: begin
          legal_s = 1'b1;
          taken_s = Zero;
        end
        OP_BNE: begin
          legal_s = 1'b1;
          taken_s = ~Zero;
        end
        OP_BGTZ: begin
          legal_s = 1'b1;
          taken_s = ~Zero & ~Sign & ~OverFlow;
        end
        OP_BLEZ: begin
          legal_s = 1'b1;
          taken_s = Zero | (Sign & ~OverFlow);
        end
        OP_REGIMM: begin
          case (BranchFlag)
            RT_BGEZ, RT_BGEZAL: begin
              legal_s = 1'b1;
              taken_s = Zero | (~Sign & ~OverFlow);
              link_s  = BranchFlag[4];
            end
            RT_BLTZ, RT_BLTZAL: begin
              legal_s = 1'b1;
              taken_s = ~Zero & Sign & ~OverFlow;
              link_s  = BranchFlag[4];
            end
            default: begin
              legal_s = 1'b0;
              taken_s = 1'b0;
              link_s  = 1'b0;
            end
          endcase
        end
        default: begin
          legal_s = 1'b0;
          taken_s = 1'b0;
          link_s  = 1'b0;
        end
      endcase
    end else begin
      legal_s = 1'b0;
      taken_s = 1'b0;
      link_s  = 1'b0;
    end
  end

  // A branch with an illegal encoding never goes taken. If fetch predicted
  // it as taken, that fetch has to be redirected, so the prediction itself
  // is reported as the mispredict.
  always_comb begin
    mispredict_s = 1'b0;
    if (legal_s) begin
      mispredict_s = taken_s ^ PredTaken;
    end else if (Branch) begin
      mispredict_s = PredTaken;
    end else begin
      mispredict_s = 1'b0;
    end
  end

  assign BranchCtr  = taken_s;
  assign Link       = link_s;
  assign Mispredict = mispredict_s;

  // Train the predictor entry of each legal resolved branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_r[i] <= INIT_STATE;
      end
    end else if (legal_s) begin
      bht_r[resolve_idx_s] <= ctr_next(bht_r[resolve_idx_s], taken_s);
    end
  end

  // Statistics counters. A clear takes priority over a branch that resolves
  // in the same cycle, and that branch is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_r  <= {CNT_W{1'b0}};
      mispred_count_r <= {CNT_W{1'b0}};
    end else if (ClearStats) begin
      branch_count_r  <= {CNT_W{1'b0}};
      mispred_count_r <= {CNT_W{1'b0}};
    end else if (legal_s) begin
      branch_count_r <= sat_inc(branch_count_r);
      if (mispredict_s) begin
        mispred_count_r <= sat_inc(mispred_count_r);
      end
    end
  end

  assign BranchCount  = branch_count_r;
  assign MispredCount = mispred_count_r;

endmodule

// File: tb/tb_branch_predict_unit_206.sv
module tb_branch_predict_unit_206;

  logic        clk;
  logic        rst_n;
  logic [31:0] FetchPC;
  logic        Branch;
  logic [5:0]  OP;
  logic [4:0]  BranchFlag;
  logic        Zero, Sign, OverFlow;
  logic [31:0] ResolvePC;
  logic        PredTaken;
  logic        ClearStats;

  logic        PredictTaken, BranchCtr, Link, Mispredict;
  logic [15:0] BranchCount, MispredCount;
  logic        PredictTaken4, BranchCtr4, Link4, Mispredict4;
  logic [3:0]  BranchCount4, MispredCount4;

  int checks = 0;
  int errors = 0;

  // Reference model state: predictor entries and uncapped event counts.
  int bht_m [64];
  int bc_m, mc_m;

  branch_predict_unit_206 dut (
    .clk(clk), .rst_n(rst_n), .FetchPC(FetchPC), .PredictTaken(PredictTaken),
    .Branch(Branch), .OP(OP), .BranchFlag(BranchFlag), .Zero(Zero), .Sign(Sign),
    .OverFlow(OverFlow), .ResolvePC(ResolvePC), .PredTaken(PredTaken),
    .ClearStats(ClearStats), .BranchCtr(BranchCtr), .Link(Link),
    .Mispredict(Mispredict), .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  branch_predict_unit_206 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .FetchPC(FetchPC), .PredictTaken(PredictTaken4),
    .Branch(Branch), .OP(OP), .BranchFlag(BranchFlag), .Zero(Zero), .Sign(Sign),
    .OverFlow(OverFlow), .ResolvePC(ResolvePC), .PredTaken(PredTaken),
    .ClearStats(ClearStats), .BranchCtr(BranchCtr4), .Link(Link4),
    .Mispredict(Mispredict4), .BranchCount(BranchCount4), .MispredCount(MispredCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic int cap(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Branch semantics. The flags describe rs compared against zero:
  // rs is negative when Sign is set without overflow, and rs is zero when
  // Zero is set.
  function automatic void model_eval(input bit br, input bit [5:0] op, input bit [4:0] fl,
                                     input bit z, input bit s, input bit o,
                                     output bit legal, output bit tk, output bit lk);
    bit neg;
    bit pos;
    legal = 0; tk = 0; lk = 0;
    neg = s && !o;
    pos = !z && !s && !o;
    if (!br) return;
    if (op == 6'd4)      begin legal = 1; tk = z; end
    else if (op == 6'd5) begin legal = 1; tk = !z; end
    else if (op == 6'd7) begin legal = 1; tk = pos; end
    else if (op == 6'd6) begin legal = 1; tk = z || neg; end
    else if (op == 6'd1) begin
      if (fl == 5'd1 || fl == 5'd17) begin legal = 1; tk = z || (!s && !o); lk = (fl == 5'd17); end
      else if (fl == 5'd0 || fl == 5'd16) begin legal = 1; tk = !z && neg; lk = (fl == 5'd16); end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    bc_m = 0;
    mc_m = 0;
  endtask

  task automatic check_counts();
    check_val("branch_count", BranchCount, cap(bc_m, 65535));
    check_val("mispred_count", MispredCount, cap(mc_m, 65535));
    check_val("branch_count4", BranchCount4, cap(bc_m, 15));
    check_val("mispred_count4", MispredCount4, cap(mc_m, 15));
  endtask

  // Run one clock cycle. Inputs are driven after the falling edge and the
  // combinational outputs are checked. Then the model steps at the rising
  // edge and the registered counters are checked.
  task automatic do_cycle(input logic [31:0] fpc, input bit br, input bit [5:0] op,
                          input bit [4:0] fl, input bit z, input bit s, input bit o,
                          input logic [31:0] rpc, input bit pt, input bit clr);
    bit legal, tk, lk, mis;
    int ri;
    @(negedge clk);
    FetchPC = fpc; Branch = br; OP = op; BranchFlag = fl; Zero = z; Sign = s;
    OverFlow = o; ResolvePC = rpc; PredTaken = pt; ClearStats = clr;
    #1;
    model_eval(br, op, fl, z, s, o, legal, tk, lk);
    mis = legal ? (tk ^ pt) : (br && pt);
    check_val("predict", PredictTaken, (bht_m[idx_of(fpc)] >= 2) ? 1 : 0);
    check_val("predict4", PredictTaken4, (bht_m[idx_of(fpc)] >= 2) ? 1 : 0);
    check_val("branchctr", BranchCtr, tk);
    check_val("link", Link, lk);
    check_val("mispredict", Mispredict, mis);
    @(posedge clk);
    if (legal) begin
      ri = idx_of(rpc);
      if (tk) bht_m[ri] = (bht_m[ri] == 3) ? 3 : bht_m[ri] + 1;
      else    bht_m[ri] = (bht_m[ri] == 0) ? 0 : bht_m[ri] - 1;
    end
    if (clr) begin
      bc_m = 0; mc_m = 0;
    end else if (legal) begin
      bc_m++;
      if (mis) mc_m++;
    end
    #1;
    check_counts();
  endtask

  task automatic random_cycles(input int n);
    bit [5:0] op;
    bit [4:0] fl;
    logic [31:0] rpc, fpc;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 7))
        0: op = 6'b000100;
        1: op = 6'b000101;
        2, 3: op = 6'b000001;
        4: op = 6'b000111;
        5: op = 6'b000110;
        6: op = 6'($urandom);
        default: op = 6'b000010;
      endcase
      case ($urandom_range(0, 4))
        0: fl = 5'b00000;
        1: fl = 5'b00001;
        2: fl = 5'b10000;
        3: fl = 5'b10001;
        default: fl = 5'($urandom);
      endcase
      rpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) fpc = rpc;
      else fpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      do_cycle(fpc, ($urandom_range(0, 4) != 0), op, fl, 1'($urandom), 1'($urandom),
               1'($urandom), rpc, 1'($urandom), ($urandom_range(0, 31) == 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; FetchPC = 32'h0; Branch = 1'b0; OP = 6'h0; BranchFlag = 5'h0;
    Zero = 1'b0; Sign = 1'b0; OverFlow = 1'b0; ResolvePC = 32'h0; PredTaken = 1'b0;
    ClearStats = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    FetchPC = 32'h40;
    #1;
    check_val("reset_predict", PredictTaken, 0);
    check_val("reset_bc", BranchCount, 0);
    check_val("reset_mc", MispredCount, 0);
    rst_n = 1'b1;
    do_cycle(32'h40, 0, 6'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);

    // Three taken beq at 0x40, each predicted not-taken.
    repeat (3) do_cycle(32'h40, 1, 6'b000100, 5'd0, 1, 0, 0, 32'h40, 0, 0);
    do_cycle(32'h40, 0, 6'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);
    check_val("beq_bc3", BranchCount, 3);
    check_val("beq_mc3", MispredCount, 3);

    // REGIMM and bgtz/blez corners.
    do_cycle(32'h0, 1, 6'b000001, 5'b00001, 0, 1, 0, 32'h80, 0, 0);
    do_cycle(32'h0, 1, 6'b000001, 5'b10001, 0, 0, 0, 32'h80, 0, 0);
    do_cycle(32'h0, 1, 6'b000001, 5'b00000, 0, 1, 0, 32'h84, 1, 0);
    do_cycle(32'h0, 1, 6'b000001, 5'b10000, 0, 1, 1, 32'h84, 1, 0);
    for (int f = 0; f < 8; f++) begin
      do_cycle(32'h0, 1, 6'b000111, 5'd0, f[0], f[1], f[2], 32'h88, 0, 0);
      do_cycle(32'h0, 1, 6'b000110, 5'd0, f[0], f[1], f[2], 32'h8C, 1, 0);
    end

    // An illegal encoding that was predicted taken.
    do_cycle(32'h0, 1, 6'b000010, 5'd0, 1, 0, 0, 32'h40, 1, 0);
    check_val("illegal_bc", BranchCount, 23);

    // Predict and resolve the same entry in the same cycle (idx 5).
    do_cycle(32'h14, 1, 6'b000100, 5'd0, 1, 0, 0, 32'h14, 0, 0);
    do_cycle(32'h14, 0, 6'd0, 5'd0, 0, 0, 0, 32'h0, 0, 0);

    // A clear in the same cycle as a legal resolve.
    do_cycle(32'h0, 1, 6'b000101, 5'd0, 0, 0, 0, 32'h20, 0, 1);
    check_val("clear_bc", BranchCount, 0);
    check_val("clear_mc", MispredCount, 0);

    // Saturation of the 4-bit counters.
    repeat (20) do_cycle(32'h0, 1, 6'b000100, 5'd0, 1, 0, 0, 32'h24, 0, 0);
    check_val("sat_bc4", BranchCount4, 4'hF);

    random_cycles(1500);

    // Assert reset in the middle of a cycle. It must act without a clock edge.
    @(negedge clk);
    Branch = 1'b0; ClearStats = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_counts();
    for (int i = 0; i < 64; i++) begin
      FetchPC = 32'(i) << 2;
      #1;
      check_val("rst_predict", PredictTaken, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    random_cycles(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
